// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MULDIV_FAST_MUL_EN to use a single-cycle combinational multiplier for MULT/MULTU.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// RUN   | one shift-add / shift-subtract iteration per cycle
// FIX   | sign correction, HI/LO load, done pulse
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dsr;
  logic             is_div;
  logic             neg_lo;
  logic             neg_hi;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = ~op[0] & srca[WIDTH-1];
  assign b_neg = ~op[0] & srcb[WIDTH-1];
  assign a_mag = a_neg ? -srca : srca;
  assign b_mag = b_neg ? -srcb : srcb;

  // acc holds the running high half (multiply) or partial remainder (divide);
  // q holds the multiplier being shifted out or the quotient being shifted in.
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub_diff;
  logic             ge;

  assign add_sum  = {1'b0, acc} + {1'b0, (q[0] ? dsr : {WIDTH{1'b0}})};
  assign shifted  = {acc, q[WIDTH-1]};
  assign ge       = shifted >= {1'b0, dsr};
  assign sub_diff = shifted[WIDTH-1:0] - dsr;

  logic [2*WIDTH-1:0] mag_prod;
  logic [2*WIDTH-1:0] prod;

`ifdef MULDIV_FAST_MUL_EN
  assign mag_prod = {{WIDTH{1'b0}}, q} * {{WIDTH{1'b0}}, dsr};
`else
  assign mag_prod = {acc, q};
`endif
  assign prod = neg_lo ? -mag_prod : mag_prod;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      q      <= '0;
      dsr    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              acc    <= '0;
              q      <= a_mag;
              dsr    <= b_mag;
              is_div <= op[1];
              // a zero divisor keeps the unsigned all-ones quotient regardless of signs
              neg_lo <= op[1] ? ((a_neg ^ b_neg) & (|srcb)) : (a_neg ^ b_neg);
              neg_hi <= a_neg;
              cnt    <= CNTW'(WIDTH);
`ifdef MULDIV_FAST_MUL_EN
              state  <= op[1] ? S_RUN : S_FIX;
`else
              state  <= S_RUN;
`endif
            end else begin
              if (hi_we) hi <= wdata;
              if (lo_we) lo <= wdata;
            end
          end
          S_RUN: begin
            if (is_div) begin
              acc <= ge ? sub_diff : shifted[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], ge};
            end else begin
              acc <= add_sum[WIDTH:1];
              q   <= {add_sum[0], q[WIDTH-1:1]};
            end
            cnt <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) state <= S_FIX;
          end
          S_FIX: begin
            if (is_div) begin
              lo <= neg_lo ? -q : q;
              hi <= neg_hi ? -acc : acc;
            end else begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int EXP_MUL_BUSY = FAST ? 1 : W + 1;
  localparam int EXP_DIV_BUSY = W + 1;

  logic         clk = 1'b0;
  logic         reset, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] srca, srcb, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;
  bit finished = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void compute(input logic [1:0] o, input logic [W-1:0] a, b,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [2*W-1:0]  p;
    sx = longint'($signed(a));
    sy = longint'($signed(b));
    ux = a;
    uy = b;
    p = '0;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin p = 64'(sx * sy); h = p[2*W-1:W]; l = p[W-1:0]; end
      2'b01: begin p = ux * uy;      h = p[2*W-1:W]; l = p[W-1:0]; end
      2'b10: begin
        if (b == '0) begin l = '1; h = a; end
        else begin l = W'(sx / sy); h = W'(sx % sy); end
      end
      default: begin
        if (b == '0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  function automatic int lat(input logic div_op);
    return (FAST && !div_op) ? 1 : W + 1;
  endfunction

  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk or posedge reset) begin : model
    logic [W-1:0] nh, nl;
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (flush) begin
        m_left <= 0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
        end
      end else if (start) begin
        compute(op, srca, srcb, nh, nl);
        p_hi   <= nh;
        p_lo   <= nl;
        m_left <= lat(op[1]);
      end else begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
      if (busy === 1'b1) nb++;
    end
    tests++;
    fails++;
    $display("FAIL wait_done: got timeout expected done pulse");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7fff_ffff;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // ---------------- stimulus and checking ----------------
  initial begin
    int nb;
    int ndone;
    reset = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; srca = '0; srcb = '0; wdata = '0;
    #12;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    @(posedge clk); #1 reset = 1'b0;

    fork
      begin : cycle_compare
        while (!finished) begin
          @(negedge clk);
          if (!reset && !finished) begin
            tests++;
            if (busy !== (m_left > 0) || done !== m_done || hi !== m_hi || lo !== m_lo) begin
              fails++;
              $display("FAIL cycle t=%0t: busy %b/%b done %b/%b hi %h/%h lo %h/%h (got/expected)",
                       $time, busy, (m_left > 0), done, m_done, hi, m_hi, lo, m_lo);
            end
          end
        end
      end
      begin : stimulus
        // MULT -2 * 3
        @(posedge clk); #1;
        issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done(nb);
        check("mult_busy_cycles", W'(nb), W'(EXP_MUL_BUSY));
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        @(negedge clk);
        check("done_width", W'(done), '0);

        // MULTU then back-to-back DIVU started in the done cycle
        @(posedge clk); #1;
        issue(2'b01, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done(nb);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);
        #1;
        issue(2'b11, 32'd100, 32'd7);
        wait_done(nb);
        check("b2b_divu_busy_cycles", W'(nb), W'(EXP_DIV_BUSY));
        check("divu_lo", lo, 32'h0000_000E);
        check("divu_hi", hi, 32'h0000_0002);

        // DIV -7 / 2
        @(posedge clk); #1;
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(nb);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        // signed overflow
        @(posedge clk); #1;
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(nb);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        // divide by zero
        @(posedge clk); #1;
        issue(2'b11, 32'h0000_0064, 32'h0000_0000);
        wait_done(nb);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'h0000_0064);

        // flush at cycle 10 of a DIV
        @(posedge clk); #1;
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", W'(busy), '0);
        check("flush_hi", hi, 32'h0000_0064);
        check("flush_lo", lo, 32'hFFFF_FFFF);
        ndone = 0;
        repeat (40) begin
          @(negedge clk);
          if (done === 1'b1) ndone++;
        end
        check("flush_no_done", W'(ndone), '0);

        // MTHI while idle
        @(posedge clk); #1 hi_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1 hi_we = 1'b0;
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'hFFFF_FFFF);

        // MTLO during a busy MULT is ignored
        @(posedge clk); #1;
        issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1 lo_we = 1'b0;
        wait_done(nb);
        check("mtlo_busy_lo", lo, 32'hFFFF_FFFA);
        check("mtlo_busy_hi", hi, 32'hFFFF_FFFF);

        // start while busy is ignored
        @(posedge clk); #1;
        issue(2'b11, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; op = 2'b00; srca = 32'd5; srcb = 32'd5;
        @(posedge clk); #1 start = 1'b0;
        wait_done(nb);
        check("start_busy_lo", lo, 32'h0000_000E);
        check("start_busy_hi", hi, 32'h0000_0002);

        // asynchronous reset mid-MULT
        @(posedge clk); #1;
        issue(2'b00, 32'h0000_1234, 32'h0000_5678);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("arst_busy", W'(busy), '0);
        check("arst_hi", hi, '0);
        check("arst_lo", lo, '0);
        @(posedge clk); #1 reset = 1'b0;

        // randomized traffic, checked every cycle by the model compare
        for (int c = 0; c < 1500; c++) begin
          @(posedge clk); #1;
          start = ($urandom_range(0, 3) == 0);
          op    = 2'($urandom_range(0, 3));
          srca  = pick();
          srcb  = pick();
          flush = ($urandom_range(0, 59) == 0);
          hi_we = !flush && ($urandom_range(0, 9) == 0);
          lo_we = !flush && ($urandom_range(0, 9) == 0);
          wdata = 32'($urandom());
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        finished = 1'b1;
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
